// File: rtl/abr_params_pkg.sv
// Shared constants and types for the adams-bridge width converters.
// abr_sipo reads its default rates and its FILL/DRAIN state type from here.
package abr_params_pkg;

  // Default narrow and wide rates. The buffer default holds one full output
  // block plus enough headroom that a read and a write can overlap.
  localparam int ABR_SIPO_IN_RATE  = 64;
  localparam int ABR_SIPO_OUT_RATE = 1088;
  localparam int ABR_SIPO_BUF_W    = 1344;

  // SIPO_DRAIN is only entered when ABR_SIPO_FLUSH_EN is defined.
  typedef enum logic [0:0] {
    SIPO_FILL  = 1'b0,
    SIPO_DRAIN = 1'b1
  } abr_sipo_state_e;

endpackage : abr_params_pkg

// File: rtl/abr_sipo.sv
// abr_sipo: serial-in / parallel-out width converter.
// Narrow words arrive on data_i. Bit 0 of each word is the oldest bit. The
// words are packed into a shift buffer above the bits already present. Once
// SIPO_OUTPUT_RATE bits are present, the low slice of the buffer is shown on
// data_o. A valid/hold handshake is used on both sides.
//
// Optional build macro: ABR_SIPO_FLUSH_EN
//   This macro adds a DRAIN state, which is entered on a write that has
//   last_i set. In DRAIN the block takes no new input. It presents the
//   remaining bits, zero-padded, in as many output words as they need. It
//   raises last_o on the final output word.
//   Without the macro, last_i is ignored, last_o is 0, and the block stays
//   in FILL.
//
// valid_o, hold_o and last_o come from flops. Their next values are decoded
// from the next pointer and the next state, so no combinational path runs
// from an input to an output.
module abr_sipo
  import abr_params_pkg::*;
#(
  parameter int SIPO_BUFFER_W    = ABR_SIPO_BUF_W,
  parameter int SIPO_PTR_W       = $clog2(SIPO_BUFFER_W + 1),
  parameter int SIPO_INPUT_RATE  = ABR_SIPO_IN_RATE,
  parameter int SIPO_OUTPUT_RATE = ABR_SIPO_OUT_RATE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        zeroize,
  input  logic                        valid_i,
  output logic                        hold_o,
  input  logic [SIPO_INPUT_RATE-1:0]  data_i,
  input  logic                        last_i,
  output logic                        valid_o,
  input  logic                        hold_i,
  output logic [SIPO_OUTPUT_RATE-1:0] data_o,
  output logic                        last_o
);

  // All pointer arithmetic and shift amounts use SIPO_PTR_W bits.
  localparam logic [SIPO_PTR_W-1:0] LP_IN      = SIPO_PTR_W'(SIPO_INPUT_RATE);
  localparam logic [SIPO_PTR_W-1:0] LP_OUT     = SIPO_PTR_W'(SIPO_OUTPUT_RATE);
  localparam logic [SIPO_PTR_W-1:0] LP_HOLD_TH = SIPO_PTR_W'(SIPO_BUFFER_W - SIPO_INPUT_RATE);
  localparam logic [SIPO_PTR_W-1:0] LP_PTR_0   = {SIPO_PTR_W{1'b0}};

  logic [SIPO_BUFFER_W-1:0] r_buf;
  logic [SIPO_PTR_W-1:0]    r_ptr;
  abr_sipo_state_e          r_state;
  logic                     r_valid;
  logic                     r_hold;
  logic                     r_last;

  logic [SIPO_BUFFER_W-1:0] w_buf_nxt;
  logic [SIPO_BUFFER_W-1:0] w_data_ext;
  logic [SIPO_BUFFER_W-1:0] w_buf_shr;
  logic [SIPO_PTR_W-1:0]    w_ptr_nxt;
  logic [SIPO_PTR_W-1:0]    w_rd_amt;
  abr_sipo_state_e          w_state_nxt;
  logic                     w_valid_nxt;
  logic                     w_hold_nxt;
  logic                     w_last_nxt;
  logic                     w_wr;
  logic                     w_rd;

  assign w_wr       = valid_i & ~r_hold;
  assign w_rd       = r_valid & ~hold_i;
  assign w_data_ext = {{(SIPO_BUFFER_W - SIPO_INPUT_RATE){1'b0}}, data_i};
  assign w_buf_shr  = r_buf >> LP_OUT;

  // How far a read moves the pointer down. In FILL a read needs
  // ptr >= OUT, so the result is always OUT. In DRAIN the result is
  // smaller only for the final, partial word.
  assign w_rd_amt   = (r_ptr < LP_OUT) ? r_ptr : LP_OUT;

`ifdef ABR_SIPO_FLUSH_EN
  assign last_o = r_last;
`else
  // last_i plays no part in this build.
  logic w_unused_last;
  assign w_unused_last = last_i;
  assign last_o        = 1'b0;
`endif

  assign data_o  = r_buf[SIPO_OUTPUT_RATE-1:0];
  assign valid_o = r_valid;
  assign hold_o  = r_hold;

  // Next buffer and next pointer. The read moves old bits down before the
  // new word lands, so the new word sits just above the bits that remain.
  always_comb begin
    w_buf_nxt = r_buf;
    w_ptr_nxt = r_ptr;
    if (w_wr && w_rd) begin
      w_buf_nxt = w_buf_shr | (w_data_ext << (r_ptr - LP_OUT));
      w_ptr_nxt = r_ptr + LP_IN - LP_OUT;
    end else if (w_wr) begin
      w_buf_nxt = r_buf | (w_data_ext << r_ptr);
      w_ptr_nxt = r_ptr + LP_IN;
    end else if (w_rd) begin
      w_buf_nxt = w_buf_shr;
      w_ptr_nxt = r_ptr - w_rd_amt;
    end else begin
      w_buf_nxt = r_buf;
      w_ptr_nxt = r_ptr;
    end
  end

  // Next FILL/DRAIN state. In the default build the state stays in FILL.
  always_comb begin
    w_state_nxt = r_state;
`ifdef ABR_SIPO_FLUSH_EN
    case (r_state)
      SIPO_FILL: begin
        if (w_wr && last_i) begin
          w_state_nxt = SIPO_DRAIN;
        end else begin
          w_state_nxt = SIPO_FILL;
        end
      end
      SIPO_DRAIN: begin
        if (w_ptr_nxt == LP_PTR_0) begin
          w_state_nxt = SIPO_FILL;
        end else begin
          w_state_nxt = SIPO_DRAIN;
        end
      end
      default: w_state_nxt = SIPO_FILL;
    endcase
`else
    w_state_nxt = SIPO_FILL;
`endif
  end

  // Handshake outputs for the next cycle, decoded from the next pointer and state.
  always_comb begin
    w_valid_nxt = 1'b0;
    w_hold_nxt  = 1'b0;
    w_last_nxt  = 1'b0;
    if (w_state_nxt == SIPO_DRAIN) begin
      w_valid_nxt = (w_ptr_nxt != LP_PTR_0);
      w_hold_nxt  = 1'b1;
      w_last_nxt  = (w_ptr_nxt <= LP_OUT);
    end else begin
      w_valid_nxt = (w_ptr_nxt >= LP_OUT);
      w_hold_nxt  = (w_ptr_nxt > LP_HOLD_TH);
      w_last_nxt  = 1'b0;
    end
  end

  // State register. rst and zeroize both clear the block and override any
  // transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || zeroize) begin
      r_buf   <= {SIPO_BUFFER_W{1'b0}};
      r_ptr   <= LP_PTR_0;
      r_state <= SIPO_FILL;
      r_valid <= 1'b0;
      r_hold  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_buf   <= w_buf_nxt;
      r_ptr   <= w_ptr_nxt;
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_hold  <= w_hold_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule : abr_sipo

// File: tb/tb_abr_sipo.sv
// Self-checking bench for abr_sipo.
// The reference model keeps the buffered message as a queue of bits, oldest
// bit first. A write pushes the bits of the new word. A read pops up to OUT
// bits. The expected handshake values follow from the queue length alone.
module tb_abr_sipo;

  localparam int IN  = 64;
  localparam int OUT = 1088;
  localparam int BUF = 1344;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           zeroize = 1'b0;
  logic           valid_i = 1'b0;
  logic [IN-1:0]  data_i = '0;
  logic           last_i = 1'b0;
  logic           hold_i = 1'b0;
  logic           hold_o;
  logic           valid_o;
  logic [OUT-1:0] data_o;
  logic           last_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bit mq[$];
  bit m_drain = 1'b0;

  always #5 clk = ~clk;

  abr_sipo #(
    .SIPO_BUFFER_W   (BUF),
    .SIPO_INPUT_RATE (IN),
    .SIPO_OUTPUT_RATE(OUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .zeroize (zeroize),
    .valid_i (valid_i),
    .hold_o  (hold_o),
    .data_i  (data_i),
    .last_i  (last_i),
    .valid_o (valid_o),
    .hold_i  (hold_i),
    .data_o  (data_o),
    .last_o  (last_o)
  );

  function automatic bit m_valid();
    return m_drain ? (mq.size() != 0) : (mq.size() >= OUT);
  endfunction

  function automatic bit m_hold();
    return m_drain ? 1'b1 : (mq.size() > BUF - IN);
  endfunction

  function automatic bit m_last();
    return m_drain && (mq.size() <= OUT);
  endfunction

  function automatic logic [OUT-1:0] m_data();
    logic [OUT-1:0] d;
    d = '0;
    for (int i = 0; i < OUT && i < mq.size(); i++) d[i] = mq[i];
    return d;
  endfunction

  // Returns the first 64-bit chunk where the two words differ, for printing.
  function automatic int diff_chunk(input logic [OUT-1:0] a, input logic [OUT-1:0] b);
    for (int k = 0; k < OUT / 64; k++)
      if (a[k*64 +: 64] !== b[k*64 +: 64]) return k;
    return 0;
  endfunction

  function automatic logic [IN-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  // One clock. The model advances with the inputs applied in this cycle.
  task automatic tick();
    bit wr, rd;
    int n;
    wr = valid_i && !m_hold();
    rd = m_valid() && !hold_i;
    @(posedge clk);
    cyc++;
    if (rst || zeroize) begin
      mq.delete();
      m_drain = 1'b0;
    end else begin
      if (rd) begin
        n = (mq.size() < OUT) ? mq.size() : OUT;
        repeat (n) void'(mq.pop_front());
      end
      if (wr) for (int i = 0; i < IN; i++) mq.push_back(data_i[i]);
`ifdef ABR_SIPO_FLUSH_EN
      if (!m_drain && wr && last_i) m_drain = 1'b1;
      else if (m_drain && rd && mq.size() == 0) m_drain = 1'b0;
`endif
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; zeroize = 1'b0; valid_i = 1'b0; hold_i = 1'b0; last_i = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b1; data_i = rnd_word(); hold_i = 1'b0;
    tick();
    rst = 1'b0; valid_i = 1'b0;
    n_vec++;
    if ({valid_o, hold_o, last_o} !== 3'b000 || data_o !== '0) begin
      n_err++;
      $display("FAIL reset vhl=%b%b%b exp=000 data_lo=%h exp 0", valid_o, hold_o, last_o, data_o[63:0]);
    end
  endtask

  task automatic test_fill17();
    logic [IN-1:0]  w [17];
    logic [OUT-1:0] blk;
    int k;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      w[i] = rnd_word(); blk[i*64 +: 64] = w[i];
      valid_i = 1'b1; data_i = w[i];
      tick();
      n_vec++;
      if ({valid_o, hold_o, last_o} !== {m_valid(), m_hold(), m_last()} || data_o !== m_data()) begin
        n_err++; k = diff_chunk(data_o, m_data());
        $display("FAIL fill17 cyc=%0d vhl=%b%b%b exp=%b%b%b chunk%0d=%h exp %h", cyc, valid_o, hold_o, last_o,
                 m_valid(), m_hold(), m_last(), k, data_o[k*64 +: 64], m_data() >> (k*64));
      end
    end
    valid_i = 1'b0;
    n_vec++;
    if (valid_o !== 1'b1 || data_o !== blk) begin
      n_err++; k = diff_chunk(data_o, blk);
      $display("FAIL fill17_block valid=%b exp 1 chunk%0d=%h exp %h", valid_o, k, data_o[k*64 +: 64], blk[k*64 +: 64]);
    end
    tick();
    n_vec++;
    if ({valid_o, hold_o} !== 2'b00 || data_o !== '0) begin
      n_err++;
      $display("FAIL fill17_after_read vh=%b%b exp 00 data_lo=%h exp 0", valid_o, hold_o, data_o[63:0]);
    end
  endtask

  task automatic test_hold_full();
    int k;
    do_reset();
    hold_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      valid_i = 1'b1; data_i = rnd_word();
      tick();
      n_vec++;
      if ({valid_o, hold_o, last_o} !== {m_valid(), m_hold(), m_last()} || data_o !== m_data()) begin
        n_err++; k = diff_chunk(data_o, m_data());
        $display("FAIL hold_full cyc=%0d vhl=%b%b%b exp=%b%b%b chunk%0d=%h exp %h", cyc, valid_o, hold_o, last_o,
                 m_valid(), m_hold(), m_last(), k, data_o[k*64 +: 64], m_data() >> (k*64));
      end
    end
    n_vec++;
    if ({valid_o, hold_o} !== 2'b11) begin
      n_err++; $display("FAIL hold_full_state vh=%b%b exp 11", valid_o, hold_o);
    end
    hold_i = 1'b0; valid_i = 1'b0;
    tick();
    n_vec++;
    if ({valid_o, hold_o} !== 2'b00 || data_o !== m_data() || data_o[OUT-1:256] !== '0) begin
      n_err++;
      $display("FAIL hold_release vh=%b%b exp 00 data_lo=%h exp %h", valid_o, hold_o, data_o[63:0], m_data() & 64'hffffffffffffffff);
    end
  endtask

  task automatic test_simul_rw();
    logic [IN-1:0] x;
    do_reset();
    hold_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      valid_i = 1'b1; data_i = rnd_word();
      tick();
    end
    n_vec++;
    if ({valid_o, hold_o} !== 2'b10) begin
      n_err++; $display("FAIL simul_full vh=%b%b exp 10", valid_o, hold_o);
    end
    x = rnd_word(); data_i = x; valid_i = 1'b1; hold_i = 1'b0;
    tick();
    valid_i = 1'b0;
    n_vec++;
    if ({valid_o, hold_o} !== 2'b00 || data_o[63:0] !== x || data_o[OUT-1:64] !== '0) begin
      n_err++;
      $display("FAIL simul_rw vh=%b%b exp 00 data_lo=%h exp %h", valid_o, hold_o, data_o[63:0], x);
    end
  endtask

  task automatic test_random();
    int k;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      valid_i = ($urandom_range(0, 9) < 7);
      hold_i  = ($urandom_range(0, 9) < 3);
      last_i  = ($urandom_range(0, 19) == 0);
      data_i  = rnd_word();
      tick();
      n_vec++;
      if ({valid_o, hold_o, last_o} !== {m_valid(), m_hold(), m_last()} || data_o !== m_data()) begin
        n_err++; k = diff_chunk(data_o, m_data());
        $display("FAIL random cyc=%0d vhl=%b%b%b exp=%b%b%b chunk%0d=%h exp %h", cyc, valid_o, hold_o, last_o,
                 m_valid(), m_hold(), m_last(), k, data_o[k*64 +: 64], m_data() >> (k*64));
      end
    end
    valid_i = 1'b0; hold_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic test_clear_midstream();
    logic [OUT-1:0] blk;
    int k;
    for (int src = 0; src < 2; src++) begin
      do_reset();
      for (int i = 0; i < 10; i++) begin
        valid_i = 1'b1; data_i = rnd_word(); hold_i = 1'b1;
        tick();
      end
      if (src == 0) zeroize = 1'b1; else rst = 1'b1;
      valid_i = 1'b1; data_i = rnd_word();
      tick();
      zeroize = 1'b0; rst = 1'b0; valid_i = 1'b0; hold_i = 1'b0;
      n_vec++;
      if ({valid_o, hold_o, last_o} !== 3'b000 || data_o !== '0) begin
        n_err++;
        $display("FAIL clear_src%0d vhl=%b%b%b exp 000 data_lo=%h exp 0", src, valid_o, hold_o, last_o, data_o[63:0]);
      end
      for (int i = 0; i < 17; i++) begin
        blk[i*64 +: 64] = rnd_word();
        valid_i = 1'b1; data_i = blk[i*64 +: 64]; hold_i = 1'b1;
        tick();
      end
      valid_i = 1'b0;
      n_vec++;
      if (valid_o !== 1'b1 || data_o !== blk) begin
        n_err++; k = diff_chunk(data_o, blk);
        $display("FAIL clear_restream_src%0d valid=%b chunk%0d=%h exp %h", src, valid_o, k, data_o[k*64 +: 64], blk[k*64 +: 64]);
      end
      hold_i = 1'b0;
    end
  endtask

`ifdef ABR_SIPO_FLUSH_EN
  task automatic test_flush_short();
    logic [OUT-1:0] blk;
    do_reset();
    blk = '0;
    for (int i = 0; i < 5; i++) begin
      blk[i*64 +: 64] = rnd_word();
      valid_i = 1'b1; data_i = blk[i*64 +: 64]; last_i = (i == 4);
      tick();
    end
    valid_i = 1'b0; last_i = 1'b0;
    n_vec++;
    if ({valid_o, hold_o, last_o} !== 3'b111 || data_o !== blk) begin
      n_err++;
      $display("FAIL flush_short vhl=%b%b%b exp 111 data_hi=%h exp 0", valid_o, hold_o, last_o, data_o[OUT-1:OUT-64]);
    end
    tick();
    n_vec++;
    if ({valid_o, hold_o, last_o} !== 3'b000) begin
      n_err++; $display("FAIL flush_short_done vhl=%b%b%b exp 000", valid_o, hold_o, last_o);
    end
  endtask

  task automatic test_flush_long();
    logic [IN-1:0]  w [20];
    logic [OUT-1:0] tail;
    do_reset();
    tail = '0;
    for (int i = 0; i < 20; i++) begin
      w[i] = rnd_word();
      valid_i = 1'b1; data_i = w[i]; last_i = (i == 19);
      tick();
      if (i == 16) begin
        n_vec++;
        if ({valid_o, last_o} !== 2'b10) begin
          n_err++; $display("FAIL flush_long_first vl=%b%b exp 10", valid_o, last_o);
        end
      end
    end
    valid_i = 1'b0; last_i = 1'b0;
    for (int i = 17; i < 20; i++) tail[(i-17)*64 +: 64] = w[i];
    n_vec++;
    if ({valid_o, hold_o, last_o} !== 3'b111 || data_o !== tail) begin
      n_err++;
      $display("FAIL flush_long_second vhl=%b%b%b exp 111 data_lo=%h exp %h", valid_o, hold_o, last_o, data_o[63:0], w[17]);
    end
    tick();
    n_vec++;
    if ({valid_o, hold_o, last_o} !== 3'b000) begin
      n_err++; $display("FAIL flush_long_done vhl=%b%b%b exp 000", valid_o, hold_o, last_o);
    end
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_fill17();
    test_hold_full();
    test_simul_rw();
    test_clear_midstream();
`ifdef ABR_SIPO_FLUSH_EN
    test_flush_short();
    test_flush_long();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_abr_sipo
